// File: rtl/quad_dec_cntr.sv
// Quadrature decoder with a wrapping up/down position counter.
// The A/B inputs are synchronized, sampled on a prescaled tick and
// debounced before the accepted state is decoded into step/direction.
module quad_dec_cntr #(
   parameter int CNT_W      = 8,
   parameter int SAMPLE_DIV = 4,
   parameter int FILT       = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_in,
   input  logic             b_in,
   input  logic             clr,
   input  logic             err_clr,
   output logic [CNT_W-1:0] pos,
   output logic             step,
   output logic             up_dn,
   output logic             err
);

   localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int FW = $clog2(FILT + 1);
   localparam logic [PW-1:0] PRESC_MAX = PW'(SAMPLE_DIV - 1);
   localparam logic [FW-1:0] FCNT_MAX  = FW'(FILT);
   localparam logic [FW-1:0] FCNT_PRE  = FW'(FILT - 1);
   localparam logic [FW-1:0] FCNT_ONE  = FW'(1);

   // Bit 1 carries phase A, bit 0 carries phase B, so {a,b} reads naturally.
   logic [1:0] raw_in;
   logic [1:0] sync1_q;
   logic [1:0] sync2_q;

   assign raw_in = {a_in, b_in};

   // Two-flop synchronizer, one chain per encoder phase.
   for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge clk) begin
         if (rst) begin
            sync1_q[gi] <= 1'b0;
            sync2_q[gi] <= 1'b0;
         end else begin
            sync1_q[gi] <= raw_in[gi];
            sync2_q[gi] <= sync1_q[gi];
         end
      end
   end

   // Prescaler: tick fires on the last count of each sample period.
   logic [PW-1:0] presc_q, presc_d;
   logic          tick;

   assign tick = (presc_q == PRESC_MAX);

   always_comb begin
      presc_d = tick ? '0 : presc_q + PW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) presc_q <= '0;
      else     presc_q <= presc_d;
   end

   // Debounce filter: a sample must repeat FILT ticks in a row to be accepted.
   logic [1:0]    cand_q, cand_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic [1:0]    filt_q, filt_d;

   always_comb begin
      cand_d = cand_q;
      fcnt_d = fcnt_q;
      filt_d = filt_q;
      if (tick) begin
         if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            fcnt_d = FCNT_ONE;
         end else if (fcnt_q == FCNT_PRE) begin
            fcnt_d = FCNT_MAX;
            filt_d = cand_q;
         end else if (fcnt_q < FCNT_PRE) begin
            fcnt_d = fcnt_q + FCNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cand_q <= '0;
         fcnt_q <= '0;
         filt_q <= '0;
      end else begin
         cand_q <= cand_d;
         fcnt_q <= fcnt_d;
         filt_q <= filt_d;
      end
   end

   // Decoder state and outputs.
   logic [1:0]       prev_q, prev_d;
   logic             primed_q, primed_d;
   logic [CNT_W-1:0] pos_q, pos_d;
   logic             step_q, step_d;
   logic             up_dn_q, up_dn_d;
   logic             err_q, err_d;
   logic [1:0]       nxt_up;
   logic [1:0]       nxt_dn;
   logic             err_set;

   // Neighbouring states of prev in the up (00->10->11->01) and down direction.
   always_comb begin
      nxt_up = 2'b00;
      nxt_dn = 2'b00;
      case (prev_q)
         2'b00: begin nxt_up = 2'b10; nxt_dn = 2'b01; end
         2'b10: begin nxt_up = 2'b11; nxt_dn = 2'b00; end
         2'b11: begin nxt_up = 2'b01; nxt_dn = 2'b10; end
         default: begin nxt_up = 2'b00; nxt_dn = 2'b11; end
      endcase
   end

   // Step/direction decode, position update, clear and sticky error.
   always_comb begin
      prev_d   = prev_q;
      primed_d = primed_q;
      pos_d    = pos_q;
      step_d   = 1'b0;
      up_dn_d  = up_dn_q;
      err_set  = 1'b0;
      if (!primed_q) begin
         // First accepted state only seeds prev, so non-zero inputs at
         // start-up do not count as a step.
         if (fcnt_q == FCNT_MAX) begin
            prev_d   = filt_q;
            primed_d = 1'b1;
         end
      end else begin
         prev_d = filt_q;
         if (filt_q == nxt_up) begin
            step_d  = 1'b1;
            up_dn_d = 1'b1;
            pos_d   = pos_q + CNT_W'(1);
         end else if (filt_q == nxt_dn) begin
            step_d  = 1'b1;
            up_dn_d = 1'b0;
            pos_d   = pos_q - CNT_W'(1);
         end else if (filt_q == ~prev_q) begin
            err_set = 1'b1;
         end
      end
      // Clear wins over a count, but step/up_dn still report the step.
      if (clr) pos_d = '0;
      if (err_set)      err_d = 1'b1;
      else if (err_clr) err_d = 1'b0;
      else              err_d = err_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q   <= '0;
         primed_q <= 1'b0;
         pos_q    <= '0;
         step_q   <= 1'b0;
         up_dn_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         prev_q   <= prev_d;
         primed_q <= primed_d;
         pos_q    <= pos_d;
         step_q   <= step_d;
         up_dn_q  <= up_dn_d;
         err_q    <= err_d;
      end
   end

   assign pos   = pos_q;
   assign step  = step_q;
   assign up_dn = up_dn_q;
   assign err   = err_q;

endmodule

// File: tb/tb_quad_dec_cntr.sv
// Directed testbench for quad_dec_cntr: one instance sampling every cycle,
// one sampling every 4th cycle for the slow-filter glitch case.
module tb_quad_dec_cntr;

   logic       clk = 1'b0;
   logic       rst, a, b, clr, err_clr;
   logic [7:0] pos;
   logic       step, up_dn, err;

   logic       rst4, a4, b4, clr4, err_clr4;
   logic [7:0] pos4;
   logic       step4, up_dn4, err4;

   int n_checks = 0;
   int n_pass   = 0;
   int step_cnt  = 0;
   int step4_cnt = 0;

   always #5 clk = ~clk;

   quad_dec_cntr #(.CNT_W(8), .SAMPLE_DIV(1), .FILT(3)) u_dut (
      .clk(clk), .rst(rst), .a_in(a), .b_in(b), .clr(clr), .err_clr(err_clr),
      .pos(pos), .step(step), .up_dn(up_dn), .err(err)
   );

   quad_dec_cntr #(.CNT_W(8), .SAMPLE_DIV(4), .FILT(3)) u_dut4 (
      .clk(clk), .rst(rst4), .a_in(a4), .b_in(b4), .clr(clr4), .err_clr(err_clr4),
      .pos(pos4), .step(step4), .up_dn(up_dn4), .err(err4)
   );

   // Count step pulses mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (step)  step_cnt++;
      if (step4) step4_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("check %-22s got=%0d exp=%0d ok", tag, got, exp);
      end else begin
         $display("FAIL %-22s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Advance n active edges, then settle 1 time unit past the last one.
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive a new A/B level, hold it 8 cycles, report when/how often step fired.
   task automatic apply(input logic na, input logic nb, output int first_at, output int nsteps);
      a = na;
      b = nb;
      first_at = -1;
      nsteps = 0;
      for (int i = 1; i <= 8; i++) begin
         cyc(1);
         if (step) begin
            nsteps++;
            if (first_at < 0) first_at = i;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int fa, ns, snap;
      rst = 1'b1; a = 1'b0; b = 1'b0; clr = 1'b0; err_clr = 1'b0;
      rst4 = 1'b1; a4 = 1'b0; b4 = 1'b0; clr4 = 1'b0; err_clr4 = 1'b0;

      // Reset state
      cyc(3);
      check("rst_pos", pos, 0);
      check("rst_step", step, 0);
      check("rst_up_dn", up_dn, 0);
      check("rst_err", err, 0);
      rst = 1'b0;
      cyc(8);

      // Full up cycle 00->10->11->01->00
      apply(1, 0, fa, ns);
      check("up1_latency", fa, 6);
      check("up1_nsteps", ns, 1);
      check("up1_pos", pos, 1);
      apply(1, 1, fa, ns);
      check("up2_nsteps", ns, 1);
      apply(0, 1, fa, ns);
      check("up3_nsteps", ns, 1);
      apply(0, 0, fa, ns);
      check("up4_latency", fa, 6);
      check("up4_nsteps", ns, 1);
      check("up_pos", pos, 4);
      check("up_up_dn", up_dn, 1);
      check("up_err", err, 0);

      // Clear, then one step down wraps to 255
      clr = 1'b1;
      cyc(1);
      clr = 1'b0;
      check("clr_pos", pos, 0);
      apply(0, 1, fa, ns);
      check("dn_nsteps", ns, 1);
      check("dn_up_dn", up_dn, 0);
      check("dn_wrap_pos", pos, 255);
      apply(0, 0, fa, ns);
      check("wrap_back_pos", pos, 0);
      check("wrap_back_up_dn", up_dn, 1);

      // 2-cycle glitch on A is rejected
      snap = step_cnt;
      a = 1'b1;
      cyc(2);
      a = 1'b0;
      cyc(8);
      check("glitch_steps", step_cnt - snap, 0);
      check("glitch_pos", pos, 0);
      check("glitch_err", err, 0);

      // Illegal 00->11 sets sticky err, no step
      apply(1, 1, fa, ns);
      check("ill_nsteps", ns, 0);
      check("ill_err", err, 1);
      check("ill_pos", pos, 0);
      err_clr = 1'b1;
      cyc(1);
      err_clr = 1'b0;
      check("errclr_err", err, 0);

      // Illegal 11->00 with err_clr in the decode cycle: set wins
      snap = step_cnt;
      a = 1'b0;
      b = 1'b0;
      cyc(5);
      err_clr = 1'b1;
      cyc(1);
      err_clr = 1'b0;
      check("ill_vs_clr_err", err, 1);
      cyc(3);
      check("ill_vs_clr_hold", err, 1);
      check("ill_vs_clr_steps", step_cnt - snap, 0);

      // Reset with inputs at 11: no spurious step after release
      rst = 1'b1;
      a = 1'b1;
      b = 1'b1;
      cyc(3);
      check("rst11_err", err, 0);
      rst = 1'b0;
      snap = step_cnt;
      cyc(10);
      check("rst11_steps", step_cnt - snap, 0);
      check("rst11_err_after", err, 0);
      apply(0, 1, fa, ns);
      check("rst11_up_nsteps", ns, 1);
      check("rst11_up_dn", up_dn, 1);
      check("rst11_pos", pos, 1);

      // Count to 7, then clr coinciding with an up step
      apply(0, 0, fa, ns);
      apply(1, 0, fa, ns);
      apply(1, 1, fa, ns);
      apply(0, 1, fa, ns);
      apply(0, 0, fa, ns);
      apply(1, 0, fa, ns);
      check("pos_before_clr", pos, 7);
      a = 1'b1;
      b = 1'b1;
      cyc(5);
      clr = 1'b1;
      cyc(1);
      clr = 1'b0;
      check("clr_step_pos", pos, 0);
      check("clr_step_step", step, 1);
      check("clr_step_up_dn", up_dn, 1);
      cyc(3);
      apply(0, 1, fa, ns);
      check("post_clr_pos", pos, 1);

      // Reset landing on a decode cycle
      a = 1'b0;
      b = 1'b0;
      cyc(5);
      rst = 1'b1;
      cyc(1);
      check("midrst_pos", pos, 0);
      check("midrst_step", step, 0);
      check("midrst_up_dn", up_dn, 0);
      check("midrst_err", err, 0);
      rst = 1'b0;
      cyc(2);

      // SAMPLE_DIV=4: 10-cycle pulse straddles only two ticks and is rejected
      rst4 = 1'b1;
      cyc(1);
      rst4 = 1'b0;
      cyc(2);
      snap = step4_cnt;
      a4 = 1'b1;
      cyc(10);
      a4 = 1'b0;
      cyc(20);
      check("div4_glitch_steps", step4_cnt - snap, 0);
      check("div4_glitch_pos", pos4, 0);
      check("div4_glitch_err", err4, 0);

      // A long level on the slow instance is accepted as one up step
      snap = step4_cnt;
      a4 = 1'b1;
      cyc(24);
      check("div4_step_count", step4_cnt - snap, 1);
      check("div4_pos", pos4, 1);
      check("div4_up_dn", up_dn4, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/quad_dec_cntr.md
# quad_dec_cntr

Quadrature decoder with a position counter. It receives the two-phase A/B signal pair from an incremental encoder (the source side of an up/down count interface) and recovers the step and direction. It drives a wrapping up/down position register, plus a step pulse and a direction flag that downstream counters and display logic consume. Inputs are asynchronous and may bounce; the block synchronizes, samples and filters them before decoding.

## Interface
Parameters:
- CNT_W, 8: width of position counter.
- SAMPLE_DIV, 4: filter sample period in clk cycles. Must be ≥1; 1 means sample every cycle.
- FILT, 3: number of consecutive equal samples required to accept a new A/B state. Must be ≥2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- a_in  in  1  encoder phase A, asynchronous.
- b_in  in  1  encoder phase B, asynchronous.
- clr  in  1  synchronous clear of pos.
- err_clr  in  1  clears sticky err.
- pos  out  CNT_W  position count, unsigned, wraps.
- step  out  1  one-cycle pulse per accepted step.
- up_dn  out  1  direction of last accepted step; 1 = up, 0 = down.
- err  out  1  sticky flag for an illegal (two-bit) state change.

## Operation
- Synchronizer: two flops per input. Reset value 0.
- Prescaler: counter runs 0..SAMPLE_DIV-1 and wraps. `tick` is asserted when the count equals SAMPLE_DIV-1. Reset value 0.
- Filter state:
  - `cand[1:0]` (sampled state).
  - `fcnt` (saturates at FILT).
  - `filt[1:0]` (accepted state).
  - All reset to 0.
- Filter behaviour, evaluated on tick with sample s = {a_sync, b_sync}:
  - s ≠ cand: cand←s, fcnt←1.
  - s = cand and fcnt = FILT-1: fcnt←FILT, filt←cand.
  - s = cand and fcnt < FILT-1: fcnt←fcnt+1.
  - s = cand and fcnt = FILT: hold.
  - No tick: hold.
- Decoder compares `filt` with `prev[1:0]` every cycle. A `primed` flag (reset 0) governs start-up:
  - Not primed and filt has been accepted at least once (first fcnt reaching FILT): prev←filt, primed←1. No step, no err. This suppresses spurious steps when the inputs are non-zero at reset.
  - Primed and filt = prev: nothing.
  - Up sequence is {a,b}: 00→10→11→01→00. One position forward: step←1, up_dn←1, pos←pos+1.
  - One position backward: step←1, up_dn←0, pos←pos-1.
  - Both bits differ: err←1; no step; pos and up_dn hold.
  - In every primed case, prev←filt.
- Arithmetic is modulo 2^CNT_W: 2^CNT_W-1 + 1 → 0, and 0 - 1 → 2^CNT_W-1.
- clr has priority over a count update in the same cycle. pos←0, but step and up_dn still update as for a normal step.
- err: set has priority over err_clr in the same cycle. err_clr alone forces err←0.
- step is 0 in every cycle that is not a decoded step.
- rst, including mid-operation, returns all registers to reset values:
  - pos = 0, step = 0, up_dn = 0, err = 0.
  - primed = 0, prev = 00, filter and prescaler at 0.
  - rst overrides clr and err_clr.

## Timing
- Reset: all outputs 0 in the cycle after the rst edge.
- Latency with SAMPLE_DIV = 1:
  - Input change before edge N.
  - sync2 updated at N+1.
  - cand at N+2.
  - filt at N+FILT+1.
  - step, pos, up_dn and err registered at N+FILT+2. With FILT = 3, step is high after edge N+5, for exactly one cycle.
- Latency with SAMPLE_DIV > 1: add up to (SAMPLE_DIV-1)·FILT cycles of tick alignment.
- Glitch rejection: a level held for fewer than FILT ticks never reaches filt.
- Maximum step rate: one step per FILT ticks. Faster input changes produce err or missed steps.
- pos, step, up_dn and err all change on the same edge.

## Test plan
- Reset with a = b = 0; FILT = 3, SAMPLE_DIV = 1, CNT_W = 8. Drive up sequence 00→10→11→01→00, each level held 8 cycles. Required: four 1-cycle step pulses, the first 6 edges after the a change; up_dn = 1; pos = 4; err = 0.
- From pos = 0, drive 00→01 (down), held 8 cycles. Required: one step, up_dn = 0, pos = 255.
- With a = b = 0, pulse a high for 2 cycles only. Required: no step, pos and err unchanged. Repeat with SAMPLE_DIV = 4 and a 10-cycle pulse: also rejected.
- Drive 00→11 directly. Required: err = 1, step never asserted, pos unchanged. Then pulse err_clr: err = 0. Then an illegal change with err_clr asserted in the decode cycle: err stays 1.
- Release rst with a = b = 1, hold 10 cycles. Required: no step, err = 0. Then drive 11→01. Required: step, up_dn = 1, pos = 1.
- Assert clr in the same cycle as a decoded up step at pos = 7. Required: pos = 0, step = 1. Assert rst while step activity is in progress. Required: next cycle pos = 0, step = 0, err = 0, up_dn = 0.
